alu_status_stage: RTL and testbench
===================================

Name: alu_status_stage

Overview:
- Registered output stage directly downstream of the ALU adder and its overflow-flag logic.
- Captures the ALU result together with carry and overflow, and derives negative and zero locally.
- Presents result and NZCV flags to the next consumer through a valid/ready handshake.
- Keeps a sticky overflow bit and a saturating overflow-event counter for debug and status readout.

Parameters:
- N, 4, data width of the ALU result (N >= 2).
- CW, 4, width of the overflow-event counter.

Ports:
- clk_i  in  1  clock; everything samples on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- valid_i  in  1  upstream ALU beat valid.
- ready_o  out  1  stage can accept a beat this cycle.
- result_i  in  N  ALU sum/result.
- c_i  in  1  ALU carry-out.
- v_i  in  1  ALU overflow flag.
- valid_o  out  1  registered beat available.
- ready_i  in  1  downstream accepts the beat.
- result_o  out  N  registered result.
- flags_o  out  4  registered {N,Z,C,V}; bit3 = N, bit0 = V.
- clear_i  in  1  synchronous clear of the sticky bit and the counter.
- sticky_v_o  out  1  set once any accepted beat had v_i = 1.
- ovf_count_o  out  CW  number of accepted beats with v_i = 1, saturating.

Behaviour:
- Reset (rst_n_i low, asynchronous): valid_o=0, result_o=0, flags_o=4'b0000, sticky_v_o=0, ovf_count_o=0. Reset asserted mid-transfer drops the held beat; no beat is emitted after release until a new accept.
- Accept: accept = valid_i && ready_o. Emit: emit = valid_o && ready_i.
- ready_o = !valid_o || ready_i (combinational). Throughput is one beat per cycle when downstream is ready.
- Latency: 1 cycle. A beat accepted at edge k appears on result_o/flags_o with valid_o=1 after edge k.
- On accept, the stage registers:
  - result_o <= result_i
  - N <= result_i[N-1]
  - Z <= (result_i == 0)
  - C <= c_i
  - V <= v_i
- Register states: EMPTY (valid_o=0) and FULL (valid_o=1).
  - EMPTY + accept -> FULL.
  - FULL + emit + accept -> FULL, loaded with the new beat (back-to-back).
  - FULL + emit + no accept -> EMPTY.
  - FULL + !ready_i -> FULL, with result_o and flags_o held stable. ready_o=0, so upstream stalls.
- Data registers change only on accept. Output values while valid_o=0 are the last captured beat and are don't-care to consumers.
- Sticky and counter:
  - sticky_v_o: set on accept with v_i=1; cleared by clear_i.
  - ovf_count_o: increments on accept with v_i=1; holds at 2^CW-1 (no wrap).
  - clear_i together with an accept where v_i=1 in the same cycle: sticky_v_o=1 and ovf_count_o=1 (the new event survives the clear).
  - clear_i alone: sticky_v_o=0, ovf_count_o=0.
  - clear_i does not affect the data path or valid_o.
- A beat that is not accepted (valid_i=1, ready_o=0) never updates the sticky bit or the counter.

Test Plan (N=4, CW=4):
- Reset, then valid_i=1, result_i=4'b1000, c_i=0, v_i=1, ready_i=1 -> next cycle valid_o=1, result_o=4'b1000, flags_o=4'b1001, sticky_v_o=1, ovf_count_o=1.
- result_i=4'b0000, c_i=1, v_i=0 accepted -> flags_o=4'b0110, with sticky and count unchanged.
- Hold ready_i=0 for 3 cycles with valid_i=1 and a changing result_i -> ready_o=0, result_o and flags_o stable, ovf_count_o unchanged. Release ready_i -> the stalled upstream beat is accepted and appears next cycle.
- 17 consecutive accepted beats with v_i=1 -> ovf_count_o reaches 15 and holds. Then clear_i with an accepted v_i=1 beat -> ovf_count_o=1, sticky_v_o=1.
- Stream of 8 beats, ready_i=1 continuously -> one beat per cycle, values in order, no drops or duplicates.
- Assert rst_n_i low asynchronously mid-cycle while FULL -> valid_o=0 and all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_status_stage.sv
// alu_status_stage
//   Registered output stage after the ALU adder / overflow logic. It captures
//   the result together with carry and overflow, and derives negative and zero
//   locally. The beat is presented downstream through a valid/ready handshake.
//   A sticky overflow bit and a saturating overflow-event counter are kept for
//   status readout.
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   valid_i      upstream beat valid
//   ready_o      stage can accept a beat this cycle
//   result_i     ALU result [N-1:0]
//   c_i, v_i     ALU carry-out / overflow
//   valid_o      registered beat available
//   ready_i      downstream accepts the beat
//   result_o     registered result [N-1:0]
//   flags_o      registered {N,Z,C,V}
//   clear_i      synchronous clear of sticky bit and counter
//   sticky_v_o   set once any accepted beat carried overflow
//   ovf_count_o  saturating count of accepted overflow beats [CW-1:0]
module alu_status_stage #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [N-1:0]  result_i,
  input  logic          c_i,
  input  logic          v_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [N-1:0]  result_o,
  output logic [3:0]    flags_o,
  input  logic          clear_i,
  output logic          sticky_v_o,
  output logic [CW-1:0] ovf_count_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   ovf_event;

  // The slot frees up in the same cycle the held beat is taken downstream.
  assign ready_o   = (state == EMPTY) || ready_i;
  assign valid_o   = (state == FULL);
  assign accept    = valid_i && ready_o;
  assign ovf_event = accept && v_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL: begin
        if (ready_i && !accept) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      result_o <= '0;
      flags_o  <= '0;
    end else if (accept) begin
      result_o <= result_i;
      flags_o  <= {result_i[N-1], (result_i == '0), c_i, v_i};
    end
  end

  // An overflow event arriving with clear_i survives the clear as the first
  // event of the new window.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sticky_v_o  <= 1'b0;
      ovf_count_o <= '0;
    end else if (clear_i) begin
      sticky_v_o  <= ovf_event;
      ovf_count_o <= ovf_event ? CW'(1) : '0;
    end else if (ovf_event) begin
      sticky_v_o <= 1'b1;
      if (ovf_count_o != '1) begin
        ovf_count_o <= ovf_count_o + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_status_stage.sv
// Testbench for alu_status_stage (N=4, CW=4): directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_alu_status_stage;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          valid_in;
  logic          ready_out;
  logic [N-1:0]  result_in;
  logic          c_in;
  logic          v_in;
  logic          valid_out;
  logic          ready_in;
  logic [N-1:0]  result_out;
  logic [3:0]    flags_out;
  logic          clear;
  logic          sticky;
  logic [CW-1:0] count;

  alu_status_stage #(.N(N), .CW(CW)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .valid_i    (valid_in),
    .ready_o    (ready_out),
    .result_i   (result_in),
    .c_i        (c_in),
    .v_i        (v_in),
    .valid_o    (valid_out),
    .ready_i    (ready_in),
    .result_o   (result_out),
    .flags_o    (flags_out),
    .clear_i    (clear),
    .sticky_v_o (sticky),
    .ovf_count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Reference model: one held beat plus status counters.
  bit       m_full;
  int       m_res;
  int       m_flags;
  bit       m_sticky;
  int       m_cnt;

  function automatic void model_reset();
    m_full = 0; m_res = 0; m_flags = 0; m_sticky = 0; m_cnt = 0;
  endfunction

  function automatic bit model_ready(input bit rdy);
    return !m_full || rdy;
  endfunction

  function automatic void model_step(input bit vld, input int res, input bit c,
                                     input bit v, input bit rdy, input bit clr);
    bit acc;
    bit ev;
    acc = vld && model_ready(rdy);
    ev  = acc && v;
    if (acc) begin
      m_res   = res;
      m_flags = ((res >> (N - 1)) & 1) * 8 + (res == 0 ? 4 : 0) + c * 2 + v;
      m_full  = 1;
    end else if (m_full && rdy) begin
      m_full = 0;
    end
    if (clr) begin
      m_sticky = ev;
      m_cnt    = ev ? 1 : 0;
    end else if (ev) begin
      m_sticky = 1;
      m_cnt    = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
    end
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, valid_out, m_full);
    check({tag, ".sticky"}, sticky, m_sticky);
    check({tag, ".count"}, count, m_cnt);
    if (m_full) begin
      check({tag, ".result"}, result_out, m_res);
      check({tag, ".flags"}, flags_out, m_flags);
    end
  endtask

  // Called just after a falling edge: drive inputs, check ready, clock once,
  // then check registered outputs at the next falling edge.
  task automatic drive(input string tag, input bit vld, input int res, input bit c,
                       input bit v, input bit rdy, input bit clr);
    valid_in  = vld;
    result_in = N'(res);
    c_in      = c;
    v_in      = v;
    ready_in  = rdy;
    clear     = clr;
    #1;
    check({tag, ".ready"}, ready_out, model_ready(rdy));
    model_step(vld, res & ((1 << N) - 1), c, v, rdy, clr);
    @(negedge clk);
    check_outputs(tag);
  endtask

  int held_res;
  int held_flags;

  initial begin
    rst_n = 1'b0; valid_in = 0; result_in = '0; c_in = 0; v_in = 0;
    ready_in = 0; clear = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset.valid", valid_out, 0);
    check("reset.result", result_out, 0);
    check("reset.flags", flags_out, 0);
    check("reset.sticky", sticky, 0);
    check("reset.count", count, 0);

    // First overflow beat: negative, non-zero, overflow.
    drive("tp1", 1, 4'b1000, 0, 1, 1, 0);
    check("tp1.flags_const", flags_out, 4'b1001);
    check("tp1.count_const", count, 1);

    // Zero result with carry, no overflow.
    drive("tp2", 1, 4'b0000, 1, 0, 1, 0);
    check("tp2.flags_const", flags_out, 4'b0110);
    check("tp2.count_const", count, 1);
    check("tp2.sticky_const", sticky, 1);

    // Stall: downstream not ready while upstream keeps offering beats.
    drive("st_load", 1, 4'b0101, 0, 0, 0, 0);
    held_res   = result_out;
    held_flags = flags_out;
    for (int i = 0; i < 3; i++) begin
      drive("stall", 1, 9 + i, 1, 1, 0, 0);
      check("stall.result_hold", result_out, held_res);
      check("stall.flags_hold", flags_out, held_flags);
      check("stall.count_hold", count, 1);
    end
    drive("release", 1, 4'b1110, 1, 1, 1, 0);
    check("release.result_const", result_out, 4'b1110);
    check("release.count_const", count, 2);

    // Saturation of the overflow counter.
    for (int i = 0; i < 17; i++) drive("sat", 1, i, 0, 1, 1, 0);
    check("sat.count_const", count, CMAX);
    drive("sat_clr", 1, 3, 0, 1, 1, 1);
    check("sat_clr.count_const", count, 1);
    check("sat_clr.sticky_const", sticky, 1);
    drive("clr_only", 0, 0, 0, 0, 1, 1);
    check("clr_only.count_const", count, 0);
    check("clr_only.sticky_const", sticky, 0);

    // Back-to-back stream: one beat per cycle, in order.
    for (int i = 0; i < 8; i++) begin
      drive("stream", 1, (i * 3 + 1) % 16, 0, 0, 1, 0);
      check("stream.order", result_out, (i * 3 + 1) % 16);
      check("stream.valid", valid_out, 1);
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 15),
            $urandom_range(0, 1), $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset mid-cycle while holding a beat.
    drive("pre_arst", 1, 4'b1011, 1, 1, 0, 0);
    check("pre_arst.valid", valid_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.valid", valid_out, 0);
    check("arst.result", result_out, 0);
    check("arst.flags", flags_out, 0);
    check("arst.sticky", sticky, 0);
    check("arst.count", count, 0);
    valid_in = 0; ready_in = 1;
    @(negedge clk);
    rst_n = 1'b1;
    drive("post_arst", 0, 0, 0, 0, 1, 0);
    check("post_arst.valid_const", valid_out, 0);
    drive("post_arst_beat", 1, 4'b0111, 0, 0, 1, 0);
    check("post_arst_beat.result_const", result_out, 4'b0111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
